// File: rtl/red_pitaya_agc_block.sv
// red_pitaya_agc_block
//   Automatic-gain normaliser. Removes an input offset, scales the signal by an
//   unsigned fixed-point gain and runs an integral loop on the scaled amplitude
//   so that it tracks a setpoint. The integrator is clamped to the gain window,
//   can be held, and can be preset.
// Ports:
//   clk_i, rstn_i      clock, synchronous active-low reset
//   signal_i           signed input sample
//   inputoffset_i      signed offset subtracted from signal_i
//   setpoint_i         unsigned amplitude target
//   ki_i               signed integral coefficient
//   gain_min_i/max_i   gain clamp window
//   enable_i           1 = integrate, 0 = hold gain
//   gain_write_i       one-cycle preset strobe, gain_val_i = preset value
//   out_sel_i          0 normalised, 1 error, 2 amplitude, 3 gain
//   signal_o           selected output (signed)
//   sat_o              normalised product clipped this sample
//   gain_lim_o         gain sits on gain_min_i or gain_max_i
//   gain_o             current gain
module red_pitaya_agc_block #(
  parameter int SIGNALBITS = 14,
  parameter int GAINBITS   = 16,
  parameter int GAINFRAC   = 8,
  parameter int KIBITS     = 16,
  parameter int ISR        = 18,
  parameter int GAIN_INIT  = 256
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic signed [SIGNALBITS-1:0] signal_i,
  input  logic signed [SIGNALBITS-1:0] inputoffset_i,
  input  logic        [SIGNALBITS-2:0] setpoint_i,
  input  logic signed [KIBITS-1:0]     ki_i,
  input  logic        [GAINBITS-1:0]   gain_min_i,
  input  logic        [GAINBITS-1:0]   gain_max_i,
  input  logic                         enable_i,
  input  logic                         gain_write_i,
  input  logic        [GAINBITS-1:0]   gain_val_i,
  input  logic        [1:0]            out_sel_i,
  output logic signed [SIGNALBITS-1:0] signal_o,
  output logic                         sat_o,
  output logic                         gain_lim_o,
  output logic        [GAINBITS-1:0]   gain_o
);

  localparam int SB  = SIGNALBITS;
  localparam int IBW = GAINBITS + ISR;
  localparam int DW  = SB + 1;
  localparam int PNW = SB + GAINBITS + 1;
  localparam int PAW = SB - 1 + GAINBITS;
  localparam int KW  = SB + KIBITS;
  localparam int SW  = IBW + 2;
  localparam logic [IBW-1:0] INT_INIT = {GAINBITS'(GAIN_INIT), {ISR{1'b0}}};

  logic signed [SB-1:0]   r_x;
  logic        [SB-2:0]   r_abs;
  logic signed [PNW-1:0]  r_pn;
  logic        [PAW-1:0]  r_pa;
  logic signed [SB-1:0]   r_err;
  logic signed [KW-1:0]   r_kim;
  logic        [IBW-1:0]  r_int;
  logic signed [SB-1:0]   r_out;
  logic                   r_sat;
  logic                   r_lim;

  logic signed [DW-1:0]   w_diff;
  logic        [DW-1:0]   w_absf;
  logic signed [SB-1:0]   w_x;
  logic        [SB-2:0]   w_abs;
  logic        [GAINBITS-1:0] w_gain;
  logic signed [PNW-1:0]  w_pn;
  logic        [PAW-1:0]  w_pa;
  logic signed [PNW-1:0]  w_ysh;
  logic        [PAW-1:0]  w_ash;
  logic signed [SB-1:0]   w_y;
  logic                   w_yclip;
  logic        [SB-2:0]   w_amp;
  logic signed [SB-1:0]   w_err;
  logic signed [SB-1:0]   w_out;
  logic signed [SW-1:0]   w_sum;
  logic signed [SW-1:0]   w_lo;
  logic signed [SW-1:0]   w_hi;
  logic signed [SW-1:0]   w_t1;
  logic        [GAINBITS-1:0] w_pv;
  logic        [IBW-1:0]  w_int_nxt;

  assign w_gain = r_int[IBW-1:ISR];

  // S1: offset removal, saturated signed sample and saturated magnitude
  always_comb begin
    w_diff = $signed({signal_i[SB-1], signal_i}) - $signed({inputoffset_i[SB-1], inputoffset_i});
    w_absf = w_diff[DW-1] ? DW'(-w_diff) : DW'(w_diff);
    if (w_diff[DW-1] != w_diff[DW-2])
      w_x = w_diff[DW-1] ? {1'b1, {(SB-1){1'b0}}} : {1'b0, {(SB-1){1'b1}}};
    else
      w_x = w_diff[SB-1:0];
    w_abs = (|w_absf[DW-1:SB-1]) ? '1 : w_absf[SB-2:0];
  end

  // S2: signed x unsigned product via a zero-extended gain operand
  assign w_pn = $signed(r_x) * $signed({1'b0, w_gain});
  assign w_pa = r_abs * w_gain;

  // S3: rescale, saturate, error and output selection
  always_comb begin
    w_ysh   = r_pn >>> GAINFRAC;
    w_ash   = r_pa >> GAINFRAC;
    w_yclip = !((&w_ysh[PNW-1:SB-1]) || !(|w_ysh[PNW-1:SB-1]));
    if (w_yclip)
      w_y = w_ysh[PNW-1] ? {1'b1, {(SB-1){1'b0}}} : {1'b0, {(SB-1){1'b1}}};
    else
      w_y = w_ysh[SB-1:0];
    w_amp = (|w_ash[PAW-1:SB-1]) ? '1 : w_ash[SB-2:0];
    w_err = $signed({1'b0, setpoint_i}) - $signed({1'b0, w_amp});
    unique case (out_sel_i)
      2'd0:    w_out = w_y;
      2'd1:    w_out = w_err;
      2'd2:    w_out = {1'b0, w_amp};
      default: w_out = {1'b0, w_gain[GAINBITS-1 -: SB-1]};
    endcase
  end

  // S5: integrator with clamp. Lower bound is applied first and the upper
  // bound second, so an inverted window resolves to the upper bound.
  always_comb begin
    w_sum = $signed({2'b00, r_int}) + $signed({{(SW-KW){r_kim[KW-1]}}, r_kim});
    w_lo  = $signed({2'b00, gain_min_i, {ISR{1'b0}}});
    w_hi  = $signed({2'b00, gain_max_i, {ISR{1'b1}}});
    w_t1  = (w_sum < w_lo) ? w_lo : w_sum;
    w_pv  = (gain_val_i < gain_min_i) ? gain_min_i : gain_val_i;
    w_pv  = (w_pv > gain_max_i) ? gain_max_i : w_pv;
    if (gain_write_i)
      w_int_nxt = {w_pv, {ISR{1'b0}}};
    else if (!enable_i)
      w_int_nxt = r_int;
    else if (w_t1 > w_hi)
      w_int_nxt = w_hi[IBW-1:0];
    else
      w_int_nxt = w_t1[IBW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_x   <= '0;
      r_abs <= '0;
      r_pn  <= '0;
      r_pa  <= '0;
      r_err <= '0;
      r_kim <= '0;
      r_out <= '0;
      r_sat <= 1'b0;
      r_lim <= 1'b0;
      r_int <= INT_INIT;
    end else begin
      r_x   <= w_x;
      r_abs <= w_abs;
      r_pn  <= w_pn;
      r_pa  <= w_pa;
      r_err <= w_err;
      r_out <= w_out;
      r_sat <= w_yclip;
      r_kim <= r_err * ki_i;
      r_int <= w_int_nxt;
      r_lim <= (w_gain == gain_min_i) || (w_gain == gain_max_i);
    end
  end

  assign signal_o   = r_out;
  assign sat_o      = r_sat;
  assign gain_lim_o = r_lim;
  assign gain_o     = w_gain;

endmodule

// File: tb/tb_red_pitaya_agc_block.sv
module tb_red_pitaya_agc_block;

  logic               clk_i = 1'b0;
  logic               rstn_i;
  logic signed [13:0] signal_i;
  logic signed [13:0] inputoffset_i;
  logic        [12:0] setpoint_i;
  logic signed [15:0] ki_i;
  logic        [15:0] gain_min_i;
  logic        [15:0] gain_max_i;
  logic               enable_i;
  logic               gain_write_i;
  logic        [15:0] gain_val_i;
  logic        [1:0]  out_sel_i;
  logic signed [13:0] signal_o;
  logic               sat_o;
  logic               gain_lim_o;
  logic        [15:0] gain_o;

  int n_vec = 0;
  int n_bad = 0;
  int peak_gain;

  red_pitaya_agc_block #(
    .SIGNALBITS(14), .GAINBITS(16), .GAINFRAC(8), .KIBITS(16), .ISR(18), .GAIN_INIT(256)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .signal_i(signal_i), .inputoffset_i(inputoffset_i),
    .setpoint_i(setpoint_i), .ki_i(ki_i), .gain_min_i(gain_min_i), .gain_max_i(gain_max_i),
    .enable_i(enable_i), .gain_write_i(gain_write_i), .gain_val_i(gain_val_i),
    .out_sel_i(out_sel_i), .signal_o(signal_o), .sat_o(sat_o), .gain_lim_o(gain_lim_o),
    .gain_o(gain_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [15:0] v);
    gain_val_i   = v;
    gain_write_i = 1'b1;
    tick();
    gain_write_i = 1'b0;
  endtask

  initial begin
    rstn_i = 1'b0; signal_i = '0; inputoffset_i = '0; setpoint_i = '0; ki_i = '0;
    gain_min_i = 16'd0; gain_max_i = 16'hFFFF; enable_i = 1'b0; gain_write_i = 1'b0;
    gain_val_i = '0; out_sel_i = 2'd0;
    tick(2);
    chk("rst_signal", $signed(signal_o), 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_lim", gain_lim_o, 0);
    chk("rst_gain", gain_o, 256);
    rstn_i = 1'b1;
    tick(4);

    // passthrough with gain 1.0 and exact 3-cycle latency
    signal_i = 14'sd1000;
    tick(2);
    chk("lat_not_yet", $signed(signal_o), 0);
    tick();
    chk("pass_pos", $signed(signal_o), 1000);
    signal_i = -14'sd1000;
    tick(3);
    chk("pass_neg", $signed(signal_o), -1000);
    chk("pass_sat", sat_o, 0);

    // preset and output saturation
    preset(16'd512);
    chk("preset_gain", gain_o, 512);
    signal_i = 14'sd3000;
    tick(3);
    chk("x2_value", $signed(signal_o), 6000);
    chk("x2_nosat", sat_o, 0);
    signal_i = 14'sd5000;
    tick(3);
    chk("x2_clip", $signed(signal_o), 8191);
    chk("x2_sat", sat_o, 1);
    chk("x2_lim", gain_lim_o, 0);

    // offset extremes
    preset(16'd256);
    signal_i = -14'sd8192;
    inputoffset_i = 14'sd8191;
    tick(3);
    chk("ofs_norm", $signed(signal_o), -8192);
    chk("ofs_nosat", sat_o, 0);
    out_sel_i = 2'd2;
    tick();
    chk("ofs_amp", $signed(signal_o), 8191);
    out_sel_i = 2'd1;
    setpoint_i = 13'd100;
    tick();
    chk("ofs_err", $signed(signal_o), 100 - 8191);
    out_sel_i = 2'd3;
    tick();
    chk("sel_gain", $signed(signal_o), 32);

    // convergence: 1000 * g / 256 -> 4000 gives g = 1024
    inputoffset_i = '0;
    signal_i = 14'sd1000;
    setpoint_i = 13'd4000;
    ki_i = 16'sd1024;
    out_sel_i = 2'd1;
    enable_i = 1'b1;
    peak_gain = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (int'(gain_o) > peak_gain) peak_gain = int'(gain_o);
    end
    chk("conv_gain", (gain_o >= 16'd1023 && gain_o <= 16'd1025), 1);
    chk("conv_err", ($signed(signal_o) >= -4 && $signed(signal_o) <= 4), 1);
    chk("conv_peak", (peak_gain <= 1030), 1);

    // clamp at gain_max, then hold
    gain_max_i = 16'd300;
    tick(200);
    chk("clamp_gain", gain_o, 300);
    chk("clamp_lim", gain_lim_o, 1);
    chk("clamp_int", (dut.r_int <= {16'd300, 18'h3FFFF}), 1);
    enable_i = 1'b0;
    setpoint_i = '0;
    tick(50);
    chk("hold_gain", gain_o, 300);
    out_sel_i = 2'd0;
    tick();
    chk("hold_pass", $signed(signal_o), (1000 * 300) / 256);
    gain_min_i = 16'd400;
    enable_i = 1'b1;
    tick(20);
    chk("inv_window", gain_o, 300);
    preset(16'd10);
    chk("preset_clamp", gain_o, 300);

    // reset during convergence
    gain_min_i = 16'd0;
    gain_max_i = 16'hFFFF;
    setpoint_i = 13'd4000;
    tick(50);
    rstn_i = 1'b0;
    tick();
    chk("mid_rst_gain", gain_o, 256);
    chk("mid_rst_sig", $signed(signal_o), 0);
    chk("mid_rst_sat", sat_o, 0);
    rstn_i = 1'b1;
    tick(2);
    chk("mid_rst_flush", $signed(signal_o), 0);
    tick();
    chk("mid_rst_resume", $signed(signal_o), 1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
